// File: rtl/aqed_fifo_multidup.sv
// aqed_fifo_multidup: A-QED self-consistency monitor for a FIFO-style core.
// Tags one "original" write, substitutes its data into NUM_DUP later writes,
// follows the read stream by transaction index and checks that every
// duplicate reads back exactly what the original read back.
module aqed_fifo_multidup #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 32,
  parameter int NUM_DUP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              exec_dup,
  input  logic              wen_in,
  input  logic              full,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              qed_done,
  output logic              qed_check,
  output logic              proto_err
);

  // dup_sent / dup_seen only ever count up to NUM_DUP (at most 7)
  localparam int SW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
  logic [CNT_W-1:0]  orig_idx;
  logic [CNT_W-1:0]  dup_idx [NUM_DUP];
  logic [DATA_W-1:0] orig_data;
  logic [DATA_W-1:0] orig_res;
  logic              orig_seen;
  logic [SW-1:0]     dup_sent;
  logic [SW-1:0]     dup_seen;

  logic               wr_ok;
  logic               in_fire;
  logic               out_fire;
  logic               in_sat;
  logic               tracking;
  logic               orig_match;
  logic               dup_hit;
  logic               issue_dup;
  logic [NUM_DUP-1:0] dup_match;

  assign wr_ok     = wen_in & ~full & ~flush;
  assign in_fire   = clk_en & wr_ok;
  assign out_fire  = clk_en & out_valid;
  assign in_sat    = &in_count;
  // Read-side index matching is only live while a check is in flight
  assign tracking  = (state == ISSUE) || (state == DRAIN);
  assign issue_dup = (state == ISSUE) && in_fire && exec_dup;

  // Substitution is purely combinational so it never depends on clk_en
  assign data_out = ((state == ISSUE) && exec_dup && wr_ok) ? orig_data : data_in;

  assign orig_match = out_fire && tracking && (out_count == orig_idx);

  // One comparator per duplicate slot; only slots already issued may match
  generate
    for (genvar gi = 0; gi < NUM_DUP; gi++) begin : g_dup_match
      assign dup_match[gi] = out_fire && (SW'(gi) < dup_sent) && (out_count == dup_idx[gi]);
    end
  endgenerate

  assign dup_hit = tracking && (|dup_match);

  // Record the write index of each duplicate as it is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DUP; k++) dup_idx[k] <= '0;
    end else if (issue_dup) begin
      for (int k = 0; k < NUM_DUP; k++) begin
        if (dup_sent == SW'(k)) dup_idx[k] <= in_count;
      end
    end
  end

  // Control FSM, transaction counters and the sticky result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_count  <= '0;
      out_count <= '0;
      orig_idx  <= '0;
      orig_data <= '0;
      orig_res  <= '0;
      orig_seen <= 1'b0;
      dup_sent  <= '0;
      dup_seen  <= '0;
      qed_done  <= 1'b0;
      qed_check <= 1'b1;
      proto_err <= 1'b0;
    end else if (clk_en) begin
      if (flush && (state != DONE)) begin
        // Abort the check in flight; the sticky results survive the flush
        state     <= IDLE;
        in_count  <= '0;
        out_count <= '0;
        dup_sent  <= '0;
        dup_seen  <= '0;
        orig_seen <= 1'b0;
      end else begin
        if (in_fire && !in_sat) in_count <= in_count + CNT_W'(1);

        if (out_fire) begin
          out_count <= out_count + CNT_W'(1);
          if (out_count >= in_count) proto_err <= 1'b1;
        end

        if (orig_match) begin
          orig_res  <= rd_data;
          orig_seen <= 1'b1;
        end

        if (dup_hit) begin
          if (rd_data != orig_res) qed_check <= 1'b0;
          dup_seen <= dup_seen + SW'(1);
        end

        case (state)
          IDLE: begin
            if (in_fire && exec_dup && !in_sat) begin
              orig_data <= data_in;
              orig_idx  <= in_count;
              dup_sent  <= '0;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (issue_dup) begin
              dup_sent <= dup_sent + SW'(1);
              if (dup_sent + SW'(1) == SW'(NUM_DUP)) state <= DRAIN;
            end
          end
          DRAIN: begin
            // A check completes only once the original itself was read back
            if ((dup_seen == SW'(NUM_DUP)) && orig_seen) begin
              state    <= DONE;
              qed_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/aqed_fifo_multidup.md
Name: aqed_fifo_multidup

Overview:
- A-QED self-consistency monitor for a FIFO-style memory core, successor to the single-duplicate FIFO checker.
- Sits between the testbench/formal driver and the FIFO write port. It tags one "original" write, then substitutes the original's data into NUM_DUP later writes.
- Tracks the read stream by transaction index and compares every duplicate's read data against the original's.
- Adds configurable width, counter width and duplicate count, flush-abort handling, counter saturation, and a sticky protocol-error flag.

Parameters:
- DATA_W, 16, data width of the write and read ports.
- CNT_W, 32, width of the transaction index counters.
- NUM_DUP, 2, number of duplicate writes per check; legal range 1..7.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; clock clk
- clk_en  input  1  global clock enable; no state changes when low
- flush  input  1  FIFO flush (FIFO contents discarded)
- exec_dup  input  1  permission to issue the original or a duplicate this cycle
- wen_in  input  1  write request from driver
- full  input  1  FIFO full
- data_in  input  DATA_W  write data from driver
- data_out  output  DATA_W  write data to FIFO (possibly substituted)
- out_valid  input  1  FIFO read transaction accepted this cycle
- rd_data  input  DATA_W  FIFO read data, qualified by out_valid
- qed_done  output  1  all NUM_DUP duplicates read and compared
- qed_check  output  1  1 while no mismatch has been seen
- proto_err  output  1  sticky: read accepted with no outstanding write

Behaviour:
- Definitions:
  - wr_ok = wen_in & ~full & ~flush
  - in_fire = clk_en & wr_ok
  - out_fire = clk_en & out_valid
- States: IDLE, ISSUE, DRAIN, DONE. Reset: IDLE, counters 0, qed_done=0, qed_check=1, proto_err=0, all valid flags 0.
- IDLE:
  - On in_fire & exec_dup & in_count != all-ones: latch orig_data=data_in and orig_idx=in_count.
  - Set dup_sent=0 and go to ISSUE.
- ISSUE: on in_fire & exec_dup, issue a duplicate.
  - Record dup_idx[dup_sent]=in_count, then increment dup_sent.
  - When dup_sent reaches NUM_DUP, go to DRAIN.
  - When exec_dup is low, writes pass through unmodified and are only counted.
- data_out: combinational.
  - Equals orig_data when state==ISSUE & exec_dup & wr_ok; otherwise equals data_in.
  - Independent of clk_en.
- in_count: increments on every in_fire and saturates at 2^CNT_W-1. No original is issued once saturated.
- out_count: increments on every out_fire.
- Index matching on out_fire compares out_count against registered indices only (minimum 1-cycle FIFO latency).
  - Match with orig_idx (state != IDLE): capture orig_res=rd_data and set orig_seen.
  - Match with dup_idx[k] (k < dup_sent): if rd_data != orig_res, clear qed_check (sticky until reset). Increment dup_seen.
- Transitions on dup_seen:
  - DRAIN moves to DONE when dup_seen==NUM_DUP, evaluated on the cycle after the last compare.
  - In DONE, qed_done=1; further traffic is counted and ignored.
- proto_err: set on out_fire when out_count >= in_count (read underflow). Sticky until reset.
- Flush (clk_en & flush) in IDLE/ISSUE/DRAIN:
  - Abort: clear in_count, out_count, dup_sent, dup_seen, orig_seen; return to IDLE.
  - qed_check and proto_err are held.
- Flush in DONE: no effect; results are held.
- Simultaneous in_fire and out_fire: both processed independently in the same cycle.
- Reset mid-operation: everything returns to reset values on the next edge. Reset overrides flush.
- clk_en low: all registers hold; data_out is still driven combinationally.

Test Plan:
- NUM_DUP=2, single write:
  - Stimulus: write 0xA5A5 with exec_dup=1, then two more writes with data 0x1111/0x2222 and exec_dup=1, then read three entries returning 0xA5A5 each.
  - Required: data_out=0xA5A5 on all three writes; qed_done=1 one cycle after the third read; qed_check=1.
- Corrupted duplicate:
  - Stimulus: same sequence, but the second duplicate's read returns 0xA5A4.
  - Required: qed_check falls to 0 after that read; qed_done rises; both hold until reset.
- exec_dup gap:
  - Stimulus: original at index 0, exec_dup=0 for writes 1-3, duplicates at indices 4 and 5.
  - Required: dup_idx={4,5}; writes 1-3 pass data_in; qed_done only after the 6th read.
- Full/flush:
  - Stimulus: wen_in with full=1 in ISSUE, then flush.
  - Required: no count or issue while full; flush returns to IDLE with in_count=0; the next exec_dup write becomes the new original at index 0.
- Underflow:
  - Stimulus: out_valid with no prior writes.
  - Required: proto_err=1 and sticky; qed_check stays 1.
- Saturation, CNT_W=4:
  - Stimulus: 15 plain writes, then an exec_dup write.
  - Required: no original issued; state stays IDLE.
